// File: rtl/breath_led_pkg.sv
// Shared definitions for the multi-channel breathing LED driver.
// Mode codes and per-channel ramp state encoding.
package breath_led_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_ON     = 2'b01;
    localparam logic [1:0] MODE_BREATH = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    typedef enum logic [1:0] {
        ST_RISE    = 2'd0,
        ST_HOLD_HI = 2'd1,
        ST_FALL    = 2'd2,
        ST_HOLD_LO = 2'd3
    } ch_state_t;

    // BREATH and BLINK run the duty ramp; OFF and ON freeze it.
    function automatic logic is_ramping(input logic [1:0] m);
        return (m == MODE_BREATH) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/breath_led_ch.sv
// One LED channel: duty ramp FSM, mode tracking, registered drive.
// Duty only moves on the shared tick, so it changes at a PWM period boundary.
module breath_led_ch
    import breath_led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int HOLD_STEPS = 0,
    parameter int INIT_DUTY  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_mode,
    input  logic                i_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_pwm,
    output logic                o_cycle_done
);

    localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] INIT = PWM_BITS'(INIT_DUTY);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    logic [1:0]          r_mode_q;
    logic [PWM_BITS-1:0] r_duty;
    ch_state_t           r_state;
    logic [HW-1:0]       r_hold_cnt;
    logic                r_pwm;
    logic                r_cycle_done;

    logic w_active;
    logic w_reload;
    logic w_step;

    // Entering a ramping mode restarts the wave; a same-clk tick is dropped.
    assign w_active = is_ramping(i_mode);
    assign w_reload = w_active && !is_ramping(r_mode_q);
    assign w_step   = w_active && i_tick && !w_reload;

    // Remember last mode to detect entry into a ramping mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mode_q <= MODE_OFF;
        else     r_mode_q <= i_mode;
    end

    // Duty ramp FSM with optional hold at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty       <= INIT;
            r_state      <= ST_RISE;
            r_hold_cnt   <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            if (w_reload) begin
                r_duty     <= INIT;
                r_state    <= ST_RISE;
                r_hold_cnt <= '0;
            end else if (w_step) begin
                unique case (r_state)
                    ST_RISE: begin
                        if (r_duty != MAX) begin
                            r_duty <= r_duty + 1'b1;
                        end else begin
                            r_hold_cnt <= '0;
                            r_state    <= (HOLD_STEPS == 0) ? ST_FALL : ST_HOLD_HI;
                        end
                    end
                    ST_HOLD_HI: begin
                        if (r_hold_cnt == HOLD_LAST) r_state <= ST_FALL;
                        else r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                    ST_FALL: begin
                        if (r_duty != '0) begin
                            r_duty <= r_duty - 1'b1;
                        end else begin
                            r_hold_cnt <= '0;
                            if (HOLD_STEPS == 0) begin
                                r_state      <= ST_RISE;
                                r_cycle_done <= 1'b1;
                            end else begin
                                r_state <= ST_HOLD_LO;
                            end
                        end
                    end
                    ST_HOLD_LO: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state      <= ST_RISE;
                            r_cycle_done <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Registered LED drive selected by the live mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            unique case (i_mode)
                MODE_OFF:    r_pwm <= 1'b0;
                MODE_ON:     r_pwm <= 1'b1;
                MODE_BREATH: r_pwm <= (i_pwm_cnt < r_duty);
                MODE_BLINK:  r_pwm <= (r_state == ST_RISE) ||
                                      (r_state == ST_HOLD_HI);
            endcase
        end
    end

    assign o_pwm        = r_pwm;
    assign o_cycle_done = r_cycle_done;

endmodule

// File: rtl/breath_led_multi.sv
// Multi-channel breathing LED driver with a shared PWM timebase.
// Channel start duties are staggered so a row breathes as a wave.
module breath_led_multi
    import breath_led_pkg::*;
#(
    parameter int CH         = 4,
    parameter int PWM_BITS   = 8,
    parameter int DIV_W      = 16,
    parameter int HOLD_STEPS = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*CH-1:0]     mode,
    input  logic [DIV_W-1:0]    step_div,
    output logic [CH-1:0]       pwm,
    output logic [CH-1:0]       cycle_done
);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DIV_W-1:0]    r_div_cnt;

    logic                w_period_end;
    logic [DIV_W-1:0]    w_div_last;
    logic                w_tick;

    // A divider of 0 behaves as 1; >= lets a lowered divider fire at once.
    assign w_period_end = &r_pwm_cnt;
    assign w_div_last   = (step_div == '0) ? '0 : step_div - 1'b1;
    assign w_tick       = w_period_end && (r_div_cnt >= w_div_last);

    // Free-running PWM counter shared by all channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pwm_cnt <= '0;
        else     r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end

    // Count PWM periods between duty steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_period_end) begin
            if (w_tick) r_div_cnt <= '0;
            else        r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        breath_led_ch #(
            .PWM_BITS   (PWM_BITS),
            .HOLD_STEPS (HOLD_STEPS),
            .INIT_DUTY  ((g * (2 ** PWM_BITS) / CH) % (2 ** PWM_BITS))
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_mode       (mode[2*g +: 2]),
            .i_tick       (w_tick),
            .i_pwm_cnt    (r_pwm_cnt),
            .o_pwm        (pwm[g]),
            .o_cycle_done (cycle_done[g])
        );
    end

endmodule

// File: tb/tb_breath_led_multi.sv
// Bench for breath_led_multi: two instances (no hold / hold of 2),
// each edge compared against a triangle-wave model of duty and pulses.
module tb_breath_led_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mode = 4'b1010;
    logic [3:0] step_div = 4'd1;
    logic [1:0] pwm_a, cd_a, pwm_b, cd_b;

    always #5 clk = ~clk;

    breath_led_multi #(
        .CH(2), .PWM_BITS(4), .DIV_W(4), .HOLD_STEPS(0)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .step_div   (step_div),
        .pwm        (pwm_a),
        .cycle_done (cd_a)
    );

    breath_led_multi #(
        .CH(2), .PWM_BITS(4), .DIV_W(4), .HOLD_STEPS(2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .step_div   (step_div),
        .pwm        (pwm_b),
        .cycle_done (cd_b)
    );

    int checks = 0;
    int errors = 0;
    int e;
    int divc;
    int ph[4];
    logic [3:0] mq;
    int pcnt[4];
    int p1st[4];
    int p2nd[4];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h",
                     tag, e, got, exp);
        end
    endtask

    function automatic int hold_of(input int c);
        return (c < 2) ? 0 : 2;
    endfunction

    function automatic int duty_of(input int t, input int h);
        if (t < 16)          return t;
        else if (t < 16 + h) return 15;
        else if (t < 32 + h) return 31 + h - t;
        else                 return 0;
    endfunction

    function automatic logic exp_led(input logic [1:0] m, input int t,
                                     input int h, input int cnt);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return cnt < duty_of(t, h);
            default: return t < 16 + h;
        endcase
    endfunction

    task automatic step();
        logic [3:0] ep;
        logic [3:0] ec;
        logic [1:0] m;
        logic [3:0] obs;
        bit tk;
        int cnt;
        int lim;
        int len;
        cnt = e % 16;
        for (int c = 0; c < 4; c++) begin
            m = mode[2*(c%2) +: 2];
            ep[c] = exp_led(m, ph[c], hold_of(c), cnt);
        end
        tk = 0;
        if (cnt == 15) begin
            lim = (step_div == 0) ? 0 : int'(step_div) - 1;
            if (divc >= lim) begin
                tk = 1;
                divc = 0;
            end else begin
                divc++;
            end
        end
        ec = '0;
        for (int c = 0; c < 4; c++) begin
            m = mode[2*(c%2) +: 2];
            len = 32 + 2 * hold_of(c);
            if (m[1] && !mq[2*(c%2)+1]) begin
                ph[c] = (c % 2) ? 8 : 0;
            end else if (tk && m[1]) begin
                if (ph[c] == len - 1) ec[c] = 1'b1;
                ph[c] = (ph[c] + 1) % len;
            end
        end
        mq = mode;
        @(posedge clk);
        #1;
        e++;
        check("pwm", {pwm_b, pwm_a}, ep);
        check("cycle_done", {cd_b, cd_a}, ec);
        obs = {cd_b, cd_a};
        for (int c = 0; c < 4; c++) begin
            if (obs[c]) begin
                pcnt[c]++;
                if (pcnt[c] == 1) p1st[c] = e;
                if (pcnt[c] == 2) p2nd[c] = e;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_pwm", {pwm_b, pwm_a}, 4'b0000);
        check("rst_cdone", {cd_b, cd_a}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        e    = 0;
        divc = 0;
        ph   = '{0, 8, 0, 8};
        mq   = '0;
        pcnt = '{0, 0, 0, 0};
        p1st = '{-1, -1, -1, -1};
        p2nd = '{-1, -1, -1, -1};
    endtask

    initial begin
        int hi;
        e = 0;
        do_reset();

        // breathing wave, staggered channels, both hold settings
        run(1056);
        check("a0_first", p1st[0], 512);
        check("a0_second", p2nd[0], 1024);
        check("a1_first", p1st[1], 384);
        check("a1_second", p2nd[1], 896);
        check("b0_first", p1st[2], 576);
        check("b1_first", p1st[3], 448);
        check("b1_second", p2nd[3], 1024);

        // asynchronous reset in the middle of a period
        run(37);
        do_reset();

        // divider of 0 behaves as 1
        step_div = 4'd0;
        run(544);
        check("sd0_a0_first", p1st[0], 512);
        check("sd0_a1_first", p1st[1], 384);

        // divider of 3, then lowered below the running count
        do_reset();
        step_div = 4'd3;
        run(1552);
        check("sd3_a0_first", p1st[0], 1536);
        check("sd3_a1_first", p1st[1], 1152);
        step_div = 4'd1;
        run(64);

        // OFF -> ON -> BREATH on ch0, BREATH entry on a tick edge
        mode = 4'b1000;
        step();
        check("off_a0", pwm_a[0], 1'b0);
        check("off_b0", pwm_b[0], 1'b0);
        mode = 4'b1001;
        step();
        check("on_a0", pwm_a[0], 1'b1);
        check("on_b0", pwm_b[0], 1'b1);
        while (e % 16 != 15) step();
        mode = 4'b1010;
        step();
        hi = 0;
        repeat (16) begin
            step();
            hi += int'(pwm_a[0]);
        end
        check("reload_p0", hi, 0);
        hi = 0;
        repeat (16) begin
            step();
            hi += int'(pwm_a[0]);
        end
        check("reload_p1", hi, 1);

        // BLINK square wave, then phase-continuous switch to BREATH
        mode = 4'b1111;
        do_reset();
        hi = 0;
        repeat (256) begin
            step();
            hi += int'(pwm_a[0]);
        end
        check("blink_hi", hi, 256);
        hi = 0;
        repeat (256) begin
            step();
            hi += int'(pwm_a[0]);
        end
        check("blink_lo", hi, 0);
        run(80);
        mode = 4'b1010;
        hi = 0;
        repeat (16) begin
            step();
            hi += int'(pwm_a[0]);
        end
        check("blink_to_breath", hi, 5);
        run(32);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
